// File: rtl/zlib_pkg.sv
// Shared constants for the zlib bitstream controller: field widths, FSM
// state encoding and the byte bit-reversal helper.
package zlib_pkg;

  localparam int DATA_WD = 32;
  localparam int NUMB_WD = 5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BPAD = 3'd3;
  localparam logic [2:0] S_ADLR = 3'd4;
  localparam logic [2:0] S_WPAD = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // The packer fills LSB first, so byte-oriented fields are bit-reversed to land verbatim.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/zlib_bs_ctrl.sv
// zlib stream sequencer: emits header, code fields, byte pad, Adler-32 trailer
// and final word pad as fields for an adjacent bit packer.
module zlib_bs_ctrl #(
  parameter int DATA_WD = zlib_pkg::DATA_WD,
  parameter int NUMB_WD = zlib_pkg::NUMB_WD
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [15:0]        cmf_flg_i,
  input  logic               cod_val_i,
  output logic               cod_rdy_o,
  input  logic [DATA_WD-1:0] cod_dat_i,
  input  logic [NUMB_WD-1:0] cod_numb_i,
  input  logic               cod_last_i,
  input  logic               adler_val_i,
  input  logic [31:0]        adler_i,
  output logic               pk_val_o,
  output logic [DATA_WD-1:0] pk_dat_o,
  output logic [NUMB_WD-1:0] pk_numb_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2:0]         last_bytes_o
);
  import zlib_pkg::*;

  logic [2:0]         r_state;
  logic [15:0]        r_hdr;
  logic [4:0]         r_pos;
  logic               r_pk_val;
  logic [DATA_WD-1:0] r_pk_dat;
  logic [NUMB_WD-1:0] r_pk_numb;
  logic [2:0]         r_last_bytes;

  logic [2:0]         w_state_next;
  logic               w_emit;
  logic [DATA_WD-1:0] w_dat;
  logic [NUMB_WD-1:0] w_numb;
  logic [DATA_WD-1:0] w_mask;

  assign w_mask = {DATA_WD{1'b1}} >> (NUMB_WD'(DATA_WD - 1) - cod_numb_i);

  always_comb begin
    w_emit       = 1'b0;
    w_dat        = '0;
    w_numb       = '0;
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_state_next = S_HDR;
      S_HDR: begin
        w_emit       = 1'b1;
        w_dat        = DATA_WD'({rev8(r_hdr[15:8]), rev8(r_hdr[7:0])});
        w_numb       = NUMB_WD'(15);
        w_state_next = S_DATA;
      end
      S_DATA: if (cod_val_i) begin
        w_emit = 1'b1;
        w_dat  = cod_dat_i & w_mask;
        w_numb = cod_numb_i;
        if (cod_last_i) w_state_next = S_BPAD;
      end
      S_BPAD: begin
        if (r_pos[2:0] != 3'd0) begin
          w_emit = 1'b1;
          w_numb = NUMB_WD'(3'd7 - r_pos[2:0]);
        end
        w_state_next = S_ADLR;
      end
      S_ADLR: if (adler_val_i) begin
        w_emit       = 1'b1;
        w_dat        = DATA_WD'({rev8(adler_i[31:24]), rev8(adler_i[23:16]),
                                 rev8(adler_i[15:8]),  rev8(adler_i[7:0])});
        w_numb       = NUMB_WD'(31);
        w_state_next = S_WPAD;
      end
      S_WPAD: begin
        if (r_pos != 5'd0) begin
          w_emit = 1'b1;
          w_numb = NUMB_WD'(5'd31 - r_pos);
        end
        w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_hdr        <= '0;
      r_pos        <= '0;
      r_pk_val     <= 1'b0;
      r_pk_dat     <= '0;
      r_pk_numb    <= '0;
      r_last_bytes <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pk_val  <= w_emit;
      r_pk_dat  <= w_dat;
      r_pk_numb <= w_numb;
      if (r_state == S_IDLE) begin
        r_pos <= '0;
        if (start_i) begin
          r_hdr        <= cmf_flg_i;
          r_last_bytes <= '0;
        end
      end else if (w_emit) begin
        r_pos <= r_pos + 5'(w_numb) + 5'd1;
      end
      // pos is byte aligned here, so its top bits count the bytes already in the word
      if (r_state == S_WPAD) begin
        r_last_bytes <= (r_pos == 5'd0) ? 3'd4 : {1'b0, r_pos[4:3]};
      end
    end
  end

  assign pk_val_o     = r_pk_val;
  assign pk_dat_o     = r_pk_dat;
  assign pk_numb_o    = r_pk_numb;
  assign last_bytes_o = r_last_bytes;
  assign cod_rdy_o    = (r_state == S_DATA);
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);

endmodule

// File: doc/zlib_bs_ctrl.md
ZLIB_BS_CTRL -- requirements
Module: zlib_bs_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WD, 32, packer field/word width; NUMB_WD, 5, field-length code width (length = numb+1).
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports:
- start_i  in  1  pulse that begins one zlib stream.
- cmf_flg_i  in  16  {CMF,FLG} header bytes, sampled on start.
- cod_val_i  in  1  code field valid.
- cod_rdy_o  out  1  code field accepted.
- cod_dat_i  in  32  code bits, LSB-aligned, already bit-ordered for the packer.
- cod_numb_i  in  5  code length minus 1.
- cod_last_i  in  1  final code of the stream.
REQ-004 SHALL have ports:
- adler_val_i  in  1  level; checksum final.
- adler_i  in  32  Adler-32 value.
REQ-005 SHALL have ports:
- pk_val_o  out  1  packer field valid.
- pk_dat_o  out  32  packer field, unused MSBs zero.
- pk_numb_o  out  5  packer field length minus 1.
REQ-006 SHALL have ports:
- busy_o  out  1  stream in progress.
- done_o  out  1  one-cycle end pulse.
- last_bytes_o  out  3  valid bytes in final packer word (1..4), held until next start.

Function
REQ-007 SHALL use a FSM with states IDLE, HDR, DATA, BPAD, ADLR, WPAD, DONE; busy_o=1 in every state except IDLE.
REQ-008 IDLE: start_i SHALL capture cmf_flg_i and move to HDR; start_i outside IDLE SHALL be ignored.
REQ-009 HDR: SHALL emit one field, dat={rev8(CMF),rev8(FLG)}, numb=15, then go to DATA (rev8 = bit reversal within a byte, so the packer writes the bytes verbatim).
REQ-010 DATA: cod_rdy_o SHALL be 1 only in DATA; each cod_val_i&cod_rdy_o SHALL emit dat=cod_dat_i masked to numb+1 bits, numb=cod_numb_i, on the next cycle.
REQ-011 DATA: acceptance with cod_last_i=1 SHALL go to BPAD.
REQ-012 SHALL keep a 5-bit bit position pos, updated as pos+numb+1 mod 32 on every emitted field, and cleared in IDLE.
REQ-013 BPAD: if pos mod 8 != 0, SHALL emit a zero field of 8-(pos mod 8) bits; otherwise SHALL emit nothing; SHALL then go to ADLR.
REQ-014 ADLR: SHALL hold with pk_val_o=0 while adler_val_i=0.
REQ-015 ADLR: once adler_val_i=1, SHALL emit one field of four rev8 bytes, adler_i[31:24] first (MSB end), numb=31, then go to WPAD.
REQ-016 WPAD: SHALL set last_bytes_o=pos/8, or 4 if pos=0.
REQ-017 WPAD: if pos!=0, SHALL emit a zero field of 32-pos bits; SHALL then go to DONE.
REQ-018 DONE: SHALL assert done_o for one cycle and return to IDLE.
REQ-019 SHALL register pk_val_o/pk_dat_o/pk_numb_o, with at most one field per cycle; HDR, BPAD, ADLR and WPAD emissions SHALL each take exactly one cycle.
REQ-020 When pk_val_o=0, pk_dat_o and pk_numb_o SHALL be 0.
REQ-021 The block SHALL NOT rely on downstream backpressure; the packer accepts every field.

Reset
REQ-022 rstn low SHALL force: state IDLE; pos, pk_val_o, pk_dat_o, pk_numb_o, cod_rdy_o, busy_o, done_o and last_bytes_o to 0; captured header to 0.
REQ-023 Reset mid-stream SHALL abandon the stream with no further fields emitted; the packer shares rstn and is cleared coherently.

Structure
REQ-024 Package zlib_pkg SHALL hold DATA_WD, NUMB_WD, the FSM state encoding and the rev8 function.
REQ-025 There SHALL be no sub-module; the packer is instantiated beside this block by the parent, pk_* wired to its val_i/dat_i/numb_i.

Verification
REQ-026 Header test: cmf_flg_i=0x789C -> first field dat=0x00001E39, numb=15, one cycle after HDR entry.
REQ-027 Unaligned test: a single 3-bit code with last -> pos=19 -> BPAD field 5 zero bits (numb 4); Adler field numb 31; WPAD 8 bits (numb 7); last_bytes_o=3; done_o pulse.
REQ-028 Aligned test: 16 bits of codes (pos=0 after last) -> no BPAD field, no WPAD field, last_bytes_o=4.
REQ-029 Adler wait test: adler_val_i delayed 10 cycles -> pk_val_o=0 throughout; Adler field emitted the cycle after adler_val_i rises.
REQ-030 Handshake test: cod_val_i held high from start -> cod_rdy_o=0 during HDR/BPAD/ADLR/WPAD; no code lost or duplicated; start_i pulse while busy_o=1 ignored.
REQ-031 Reset test: rstn pulsed mid-DATA -> all outputs 0 at once; next start produces a clean stream matching the golden zlib bytes.
